// File: rtl/mempool_dma_multi_frontend_if.sv
// Bundles the register port and the backend dispatch signals of the DMA frontend.
// The slave modport is the frontend's view; master is the driver's view.
interface mempool_dma_multi_frontend_if #(
    parameter int unsigned AddrWidth   = 32,
    parameter int unsigned DataWidth   = 32,
    parameter int unsigned NumBackends = 4,
    parameter int unsigned DmaIdWidth  = 8
);
    logic                   reg_valid_i;
    logic                   reg_write_i;
    logic [4:0]             reg_addr_i;
    logic [DataWidth-1:0]   reg_wdata_i;
    logic                   reg_ready_o;
    logic [DataWidth-1:0]   reg_rdata_o;
    logic                   reg_error_o;
    logic [AddrWidth-1:0]   burst_src_o;
    logic [AddrWidth-1:0]   burst_dst_o;
    logic [AddrWidth-1:0]   burst_num_bytes_o;
    logic [DmaIdWidth-1:0]  burst_id_o;
    logic [NumBackends-1:0] valid_o;
    logic [NumBackends-1:0] ready_i;
    logic [NumBackends-1:0] backend_idle_i;
    logic [NumBackends-1:0] trans_complete_i;
    logic                   idle_o;

    modport slave (
        input  reg_valid_i, reg_write_i, reg_addr_i, reg_wdata_i,
        output reg_ready_o, reg_rdata_o, reg_error_o,
        output burst_src_o, burst_dst_o, burst_num_bytes_o, burst_id_o, valid_o,
        input  ready_i, backend_idle_i, trans_complete_i,
        output idle_o
    );

    modport master (
        output reg_valid_i, reg_write_i, reg_addr_i, reg_wdata_i,
        input  reg_ready_o, reg_rdata_o, reg_error_o,
        input  burst_src_o, burst_dst_o, burst_num_bytes_o, burst_id_o, valid_o,
        output ready_i, backend_idle_i, trans_complete_i,
        input  idle_o
    );
endinterface

// File: rtl/mempool_dma_multi_frontend.sv
// Register-programmed DMA frontend: software stages SRC/DST/NUM_BYTES, a NEXT_ID read
// enqueues the burst, and queued bursts are handed in order to one of NumBackends backends.
module mempool_dma_multi_frontend #(
    parameter int unsigned AddrWidth   = 32,
    parameter int unsigned DataWidth   = 32,
    parameter int unsigned NumBackends = 4,
    parameter int unsigned QueueDepth  = 4,
    parameter int unsigned DmaIdWidth  = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    mempool_dma_multi_frontend_if.slave bus
);
    localparam int unsigned QW = $clog2(QueueDepth);
    localparam int unsigned QC = QW + 1;
    localparam int unsigned TW = (NumBackends > 1) ? $clog2(NumBackends) : 1;
    localparam int unsigned TC = TW + 1;
    localparam int unsigned CW = $clog2(NumBackends + 1);

    localparam logic [4:0] ADDR_SRC    = 5'h00;
    localparam logic [4:0] ADDR_DST    = 5'h04;
    localparam logic [4:0] ADDR_NUM    = 5'h08;
    localparam logic [4:0] ADDR_NEXT   = 5'h0C;
    localparam logic [4:0] ADDR_DONE   = 5'h10;
    localparam logic [4:0] ADDR_STATUS = 5'h14;

    // OPEN: no target chosen yet; LOCK: target held until handshake; GAP: one dead cycle after a pop
    typedef enum logic [1:0] {S_OPEN, S_LOCK, S_GAP} disp_state_t;

    logic [AddrWidth-1:0]  r_src, r_dst, r_num;
    logic [DmaIdWidth-1:0] r_next_id, r_completed;
    logic [AddrWidth-1:0]  r_q_src [QueueDepth];
    logic [AddrWidth-1:0]  r_q_dst [QueueDepth];
    logic [AddrWidth-1:0]  r_q_num [QueueDepth];
    logic [DmaIdWidth-1:0] r_q_id  [QueueDepth];
    logic [QW:0]           r_wptr, r_rptr;
    disp_state_t           r_state, w_state_next;
    logic [TW-1:0]         r_target, r_rr_ptr, w_target_next, w_rr_next;

    logic [QW:0]            w_count;
    logic                   w_empty, w_full, w_idle;
    logic                   w_head_valid, w_pop, w_push, w_wr_en, w_ready, w_error;
    logic [TW-1:0]          w_pick, w_target;
    logic [TC-1:0]          w_sum;
    logic                   w_found;
    logic [NumBackends-1:0] w_valid;
    logic [CW-1:0]          w_cmpl_cnt;
    logic [DataWidth-1:0]   w_rdata, w_status;

    assign w_count      = r_wptr - r_rptr;
    assign w_empty      = (w_count == '0);
    assign w_full       = (w_count == QC'(QueueDepth));
    assign w_idle       = rst_i ? (&bus.backend_idle_i) : (w_empty && (&bus.backend_idle_i));
    assign w_head_valid = !rst_i && !w_empty && (r_state != S_GAP);
    assign w_target     = (r_state == S_LOCK) ? r_target : w_pick;
    assign w_pop        = w_head_valid && bus.ready_i[w_target];

    // Search cyclically from rr_ptr for the first idle backend; fall back to rr_ptr itself
    always_comb begin
        w_pick  = r_rr_ptr;
        w_found = 1'b0;
        w_sum   = '0;
        for (int i = 0; i < NumBackends; i++) begin
            w_sum = {1'b0, r_rr_ptr} + TC'(i);
            if (w_sum >= TC'(NumBackends)) w_sum = w_sum - TC'(NumBackends);
            if (!w_found && bus.backend_idle_i[w_sum[TW-1:0]]) begin
                w_pick  = w_sum[TW-1:0];
                w_found = 1'b1;
            end
        end
    end

    // Dispatch next-state: lock on first sight of a head, release and insert a gap on handshake
    always_comb begin
        w_state_next  = r_state;
        w_target_next = r_target;
        w_rr_next     = r_rr_ptr;
        if (w_pop) begin
            w_state_next = S_GAP;
            w_rr_next    = (w_target == TW'(NumBackends - 1)) ? '0 : w_target + 1'b1;
        end else if (w_head_valid) begin
            w_state_next  = S_LOCK;
            w_target_next = w_target;
        end else if (r_state == S_GAP) begin
            w_state_next = S_OPEN;
        end
    end

    // One-hot valid toward the chosen backend while a dispatchable head exists
    always_comb begin
        w_valid = '0;
        if (w_head_valid) w_valid[w_target] = 1'b1;
    end

    // Count every completion pulse seen this cycle, including simultaneous ones
    always_comb begin
        w_cmpl_cnt = '0;
        for (int i = 0; i < NumBackends; i++) w_cmpl_cnt = w_cmpl_cnt + CW'(bus.trans_complete_i[i]);
    end

    // STATUS word: idle, full, queue count and the ID the next enqueue will receive
    always_comb begin
        w_status                    = '0;
        w_status[0]                 = w_idle;
        w_status[1]                 = w_full;
        w_status[15:8]              = 8'(w_count);
        w_status[16 +: DmaIdWidth]  = r_next_id;
    end

    // Register decode; only a NEXT_ID read against a full queue stalls the port
    always_comb begin
        w_rdata = '0;
        w_error = 1'b0;
        w_ready = 1'b1;
        w_wr_en = 1'b0;
        w_push  = 1'b0;
        if (!bus.reg_write_i && (bus.reg_addr_i == ADDR_NEXT) && w_full) w_ready = 1'b0;
        if (bus.reg_write_i) begin
            case (bus.reg_addr_i)
                ADDR_SRC, ADDR_DST, ADDR_NUM: w_wr_en = bus.reg_valid_i;
                default:                      w_error = 1'b1;
            endcase
        end else begin
            case (bus.reg_addr_i)
                ADDR_SRC:    w_rdata = DataWidth'(r_src);
                ADDR_DST:    w_rdata = DataWidth'(r_dst);
                ADDR_NUM:    w_rdata = DataWidth'(r_num);
                ADDR_NEXT: begin
                    if (r_num != '0) begin
                        w_rdata = DataWidth'(r_next_id);
                        w_push  = bus.reg_valid_i && !w_full;
                    end else begin
                        w_error = 1'b1;
                    end
                end
                ADDR_DONE:   w_rdata = DataWidth'(r_completed);
                ADDR_STATUS: w_rdata = w_status;
                default:     w_error = 1'b1;
            endcase
        end
    end

    // Descriptor storage, written at the tail when a burst is enqueued
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_q_src[r_wptr[QW-1:0]] <= r_src;
            r_q_dst[r_wptr[QW-1:0]] <= r_dst;
            r_q_num[r_wptr[QW-1:0]] <= r_num;
            r_q_id[r_wptr[QW-1:0]]  <= r_next_id;
        end
    end

    // Programming registers, queue pointers, dispatch state and completion counter
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_src       <= '0;
            r_dst       <= '0;
            r_num       <= '0;
            r_next_id   <= '0;
            r_completed <= '0;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_state     <= S_OPEN;
            r_target    <= '0;
            r_rr_ptr    <= '0;
        end else begin
            if (w_wr_en) begin
                case (bus.reg_addr_i)
                    ADDR_SRC: r_src <= bus.reg_wdata_i[AddrWidth-1:0];
                    ADDR_DST: r_dst <= bus.reg_wdata_i[AddrWidth-1:0];
                    ADDR_NUM: r_num <= bus.reg_wdata_i[AddrWidth-1:0];
                    default:  ;
                endcase
            end
            if (w_push) begin
                r_wptr    <= r_wptr + 1'b1;
                r_next_id <= r_next_id + 1'b1;
            end
            if (w_pop) r_rptr <= r_rptr + 1'b1;
            r_state     <= w_state_next;
            r_target    <= w_target_next;
            r_rr_ptr    <= w_rr_next;
            r_completed <= r_completed + DmaIdWidth'(w_cmpl_cnt);
        end
    end

    assign bus.reg_ready_o       = w_ready;
    assign bus.reg_rdata_o       = w_rdata;
    assign bus.reg_error_o       = w_error;
    assign bus.burst_src_o       = rst_i ? '0 : r_q_src[r_rptr[QW-1:0]];
    assign bus.burst_dst_o       = rst_i ? '0 : r_q_dst[r_rptr[QW-1:0]];
    assign bus.burst_num_bytes_o = rst_i ? '0 : r_q_num[r_rptr[QW-1:0]];
    assign bus.burst_id_o        = rst_i ? '0 : r_q_id[r_rptr[QW-1:0]];
    assign bus.valid_o           = w_valid;
    assign bus.idle_o            = w_idle;
endmodule

// File: tb/tb_mempool_dma_multi_frontend.sv
// Bench for the DMA frontend: a queue-level model checks the default instance every cycle,
// directed sequences pin literal values, and a second instance with 2-bit IDs checks wrap-around.
module tb_mempool_dma_multi_frontend;
    localparam int NB = 4;
    localparam int QD = 4;

    logic clk = 1'b0;
    logic rst, rst2;
    always #5 clk = ~clk;

    mempool_dma_multi_frontend_if #(.AddrWidth(32), .DataWidth(32), .NumBackends(4), .DmaIdWidth(8)) if1 ();
    mempool_dma_multi_frontend_if #(.AddrWidth(32), .DataWidth(32), .NumBackends(4), .DmaIdWidth(2)) if2 ();

    mempool_dma_multi_frontend #(.AddrWidth(32), .DataWidth(32), .NumBackends(4), .QueueDepth(4), .DmaIdWidth(8))
        u_dut (.clk_i(clk), .rst_i(rst), .bus(if1.slave));
    mempool_dma_multi_frontend #(.AddrWidth(32), .DataWidth(32), .NumBackends(4), .QueueDepth(4), .DmaIdWidth(2))
        u_dut2 (.clk_i(clk), .rst_i(rst2), .bus(if2.slave));

    int tests_run = 0;
    int tests_failed = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model of the default instance ----------------
    typedef struct {
        logic [31:0] src;
        logic [31:0] dst;
        logic [31:0] num;
        logic [7:0]  id;
    } desc_t;

    desc_t       mq[$];
    logic [31:0] m_src, m_dst, m_num;
    logic [7:0]  m_next_id, m_completed;
    int          m_rr, m_tgt, m_cyc, m_last_pop;

    function automatic int pick(input int rr, input logic [3:0] idl);
        for (int i = 0; i < NB; i++) begin
            if (idl[(rr + i) % NB]) return (rr + i) % NB;
        end
        return rr;
    endfunction

    always @(negedge clk) begin : model
        logic        exp_head, exp_idle, exp_full, exp_rdy, exp_err, push;
        logic [3:0]  exp_valid;
        logic [31:0] exp_rd;
        m_cyc++;
        if (rst) begin
            chk("rst_valid", if1.valid_o, 4'b0);
            chk("rst_burst_src", if1.burst_src_o, 0);
            chk("rst_burst_dst", if1.burst_dst_o, 0);
            chk("rst_burst_num", if1.burst_num_bytes_o, 0);
            chk("rst_burst_id", if1.burst_id_o, 0);
            chk("rst_idle", if1.idle_o, &if1.backend_idle_i);
            mq.delete();
            m_src = 0; m_dst = 0; m_num = 0; m_next_id = 0; m_completed = 0;
            m_rr = 0; m_tgt = -1; m_last_pop = -10;
        end else begin
            exp_head = (mq.size() > 0) && (m_cyc - m_last_pop > 1);
            if (exp_head && m_tgt < 0) m_tgt = pick(m_rr, if1.backend_idle_i);
            exp_valid = exp_head ? (4'b0001 << m_tgt) : 4'b0000;
            exp_idle  = (mq.size() == 0) && (&if1.backend_idle_i);
            exp_full  = (mq.size() == QD);
            chk("valid_o", if1.valid_o, exp_valid);
            chk("idle_o", if1.idle_o, exp_idle);
            if (exp_head) begin
                chk("burst_src", if1.burst_src_o, mq[0].src);
                chk("burst_dst", if1.burst_dst_o, mq[0].dst);
                chk("burst_num", if1.burst_num_bytes_o, mq[0].num);
                chk("burst_id", if1.burst_id_o, mq[0].id);
            end
            push = 1'b0;
            if (if1.reg_valid_i) begin
                exp_rdy = !(!if1.reg_write_i && if1.reg_addr_i == 5'h0C && exp_full);
                chk("reg_ready", if1.reg_ready_o, exp_rdy);
                if (exp_rdy) begin
                    exp_rd = 0;
                    exp_err = 1'b0;
                    if (if1.reg_write_i) begin
                        case (if1.reg_addr_i)
                            5'h00:   m_src = if1.reg_wdata_i;
                            5'h04:   m_dst = if1.reg_wdata_i;
                            5'h08:   m_num = if1.reg_wdata_i;
                            default: exp_err = 1'b1;
                        endcase
                    end else begin
                        case (if1.reg_addr_i)
                            5'h00: exp_rd = m_src;
                            5'h04: exp_rd = m_dst;
                            5'h08: exp_rd = m_num;
                            5'h0C: if (m_num != 0) begin exp_rd = {24'h0, m_next_id}; push = 1'b1; end
                                   else exp_err = 1'b1;
                            5'h10: exp_rd = {24'h0, m_completed};
                            5'h14: exp_rd = {8'h0, m_next_id, 8'(mq.size()), 6'b0, exp_full, exp_idle};
                            default: exp_err = 1'b1;
                        endcase
                    end
                    chk("reg_rdata", if1.reg_rdata_o, exp_rd);
                    chk("reg_error", if1.reg_error_o, exp_err);
                end
            end
            if (exp_head && if1.ready_i[m_tgt]) begin
                void'(mq.pop_front());
                m_rr = (m_tgt + 1) % NB;
                m_tgt = -1;
                m_last_pop = m_cyc;
            end
            if (push) begin
                mq.push_back(desc_t'{m_src, m_dst, m_num, m_next_id});
                m_next_id++;
            end
            m_completed = m_completed + 8'($countones(if1.trans_complete_i));
        end
    end

    // ---------------- register access helpers ----------------
    task automatic reg_acc(input int which, input logic wr, input logic [4:0] addr,
                           input logic [31:0] wdata, output logic [31:0] rdata, output logic err);
        logic rdy;
        int n;
        @(posedge clk); #1;
        if (which == 0) begin
            if1.reg_valid_i = 1'b1; if1.reg_write_i = wr; if1.reg_addr_i = addr; if1.reg_wdata_i = wdata;
        end else begin
            if2.reg_valid_i = 1'b1; if2.reg_write_i = wr; if2.reg_addr_i = addr; if2.reg_wdata_i = wdata;
        end
        rdy = 1'b0; n = 0; rdata = 0; err = 1'b0;
        while (!rdy && n < 50) begin
            @(negedge clk);
            rdy = (which == 0) ? if1.reg_ready_o : if2.reg_ready_o;
            if (rdy) begin
                rdata = (which == 0) ? if1.reg_rdata_o : if2.reg_rdata_o;
                err   = (which == 0) ? if1.reg_error_o : if2.reg_error_o;
            end else begin
                @(posedge clk); #1;
            end
            n++;
        end
        if (!rdy) begin
            tests_run++;
            tests_failed++;
            $display("FAIL reg_timeout: dut%0d addr 0x%02h never accepted, required ready=1", which, addr);
        end
        @(posedge clk); #1;
        if (which == 0) if1.reg_valid_i = 1'b0; else if2.reg_valid_i = 1'b0;
        $display("[TB] dut%0d %s addr=0x%02h wdata=0x%08h rdata=0x%08h err=%0b",
                 which, wr ? "WR" : "RD", addr, wdata, rdata, err);
    endtask

    task automatic wr(input int which, input logic [4:0] addr, input logic [31:0] d);
        logic [31:0] rd;
        logic e;
        reg_acc(which, 1'b1, addr, d, rd, e);
    endtask

    task automatic wr_err(input int which, input logic [4:0] addr, input logic [31:0] d, input string name);
        logic [31:0] rd;
        logic e;
        reg_acc(which, 1'b1, addr, d, rd, e);
        chk(name, e, 1'b1);
    endtask

    task automatic rd_exp(input int which, input logic [4:0] addr, input logic [31:0] exp_d,
                          input logic exp_e, input string name);
        logic [31:0] rd;
        logic e;
        reg_acc(which, 1'b0, addr, 32'h0, rd, e);
        chk({name, "_data"}, rd, exp_d);
        chk({name, "_err"}, e, exp_e);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin : stim
        logic ok;
        int n;
        rst = 1'b1; rst2 = 1'b1;
        if1.reg_valid_i = 0; if1.reg_write_i = 0; if1.reg_addr_i = 0; if1.reg_wdata_i = 0;
        if1.ready_i = 0; if1.backend_idle_i = 4'hF; if1.trans_complete_i = 0;
        if2.reg_valid_i = 0; if2.reg_write_i = 0; if2.reg_addr_i = 0; if2.reg_wdata_i = 0;
        if2.ready_i = 4'hF; if2.backend_idle_i = 4'hF; if2.trans_complete_i = 0;
        repeat (2) @(posedge clk);
        #1; rst = 1'b0; rst2 = 1'b0;

        // reset state
        rd_exp(0, 5'h14, 32'h0000_0001, 1'b0, "reset_status");
        rd_exp(0, 5'h10, 32'h0, 1'b0, "reset_completed");
        rd_exp(0, 5'h00, 32'h0, 1'b0, "reset_src");

        // T1: single transfer
        wr(0, 5'h00, 32'h1000);
        wr(0, 5'h04, 32'h8000);
        wr(0, 5'h08, 32'd64);
        rd_exp(0, 5'h0C, 32'h0, 1'b0, "t1_id");
        @(negedge clk);
        chk("t1_valid", if1.valid_o, 4'b0001);
        chk("t1_src", if1.burst_src_o, 32'h1000);
        chk("t1_dst", if1.burst_dst_o, 32'h8000);
        chk("t1_num", if1.burst_num_bytes_o, 32'd64);
        chk("t1_bid", if1.burst_id_o, 8'd0);
        @(posedge clk); #1; if1.ready_i = 4'b0001;
        @(posedge clk); #1; if1.ready_i = 4'b0000; if1.trans_complete_i = 4'b0001;
        @(posedge clk); #1; if1.trans_complete_i = 4'b0000;
        @(negedge clk);
        chk("t1_idle", if1.idle_o, 1'b1);
        rd_exp(0, 5'h10, 32'd1, 1'b0, "t1_completed");
        rd_exp(0, 5'h14, 32'h0001_0001, 1'b0, "t1_status");

        // T2: queue full stalls the NEXT_ID read until a pop frees a slot
        pulse_reset();
        wr(0, 5'h08, 32'd16);
        for (int i = 0; i < 4; i++) rd_exp(0, 5'h0C, 32'(i), 1'b0, "t2_id");
        @(posedge clk); #1;
        if1.reg_valid_i = 1'b1; if1.reg_write_i = 1'b0; if1.reg_addr_i = 5'h0C;
        repeat (3) begin
            @(negedge clk);
            chk("t2_stall", if1.reg_ready_o, 1'b0);
            @(posedge clk); #1;
        end
        if1.ready_i = 4'b0001;
        ok = 1'b0; n = 0;
        while (!ok && n < 10) begin
            @(negedge clk);
            if (if1.reg_ready_o) begin
                ok = 1'b1;
                chk("t2_fifth_id", if1.reg_rdata_o, 32'd4);
                chk("t2_latency", n, 1);
            end else begin
                @(posedge clk); #1;
                n++;
            end
        end
        chk("t2_accepted", ok, 1'b1);
        @(posedge clk); #1;
        if1.reg_valid_i = 1'b0; if1.ready_i = 4'b0000;
        $display("[TB] dut0 RD addr=0x0c stalled read completed after %0d cycles", n);

        // T3: round-robin start point and idle preference, target held while valid
        pulse_reset();
        wr(0, 5'h08, 32'd32);
        if1.backend_idle_i = 4'b0010;
        rd_exp(0, 5'h0C, 32'd0, 1'b0, "t3_id0");
        @(negedge clk);
        chk("t3_tgt1", if1.valid_o, 4'b0010);
        @(posedge clk); #1; if1.ready_i = 4'b0010;
        @(posedge clk); #1; if1.ready_i = 4'b0000; if1.backend_idle_i = 4'b1011;
        rd_exp(0, 5'h0C, 32'd1, 1'b0, "t3_id1");
        @(negedge clk);
        chk("t3_tgt3", if1.valid_o, 4'b1000);
        @(posedge clk); #1; if1.ready_i = 4'b0111; if1.backend_idle_i = 4'b0001;
        @(negedge clk);
        chk("t3_hold_a", if1.valid_o, 4'b1000);
        @(posedge clk); #1; if1.ready_i = 4'b0101;
        @(negedge clk);
        chk("t3_hold_b", if1.valid_o, 4'b1000);
        @(posedge clk); #1; if1.ready_i = 4'b1000;
        @(posedge clk); #1; if1.ready_i = 4'b0000; if1.backend_idle_i = 4'b0000;
        rd_exp(0, 5'h0C, 32'd2, 1'b0, "t3_id2");
        @(negedge clk);
        chk("t3_busy_tgt0", if1.valid_o, 4'b0001);
        @(posedge clk); #1; if1.ready_i = 4'b0001;
        @(posedge clk); #1; if1.ready_i = 4'b0000; if1.backend_idle_i = 4'b1111;

        // T4: error paths leave state untouched
        wr(0, 5'h00, 32'h1234);
        wr(0, 5'h08, 32'd0);
        rd_exp(0, 5'h0C, 32'd0, 1'b1, "t4_num0");
        rd_exp(0, 5'h14, 32'h0003_0001, 1'b0, "t4_status");
        wr_err(0, 5'h0C, 32'hDEAD, "t4_wr_ro");
        wr_err(0, 5'h18, 32'hBEEF, "t4_wr_unmapped");
        rd_exp(0, 5'h00, 32'h1234, 1'b0, "t4_src_kept");
        rd_exp(0, 5'h08, 32'd0, 1'b0, "t4_num_kept");

        // T6: reset while descriptors are queued and one is offered
        wr(0, 5'h08, 32'd8);
        rd_exp(0, 5'h0C, 32'd3, 1'b0, "t6_id3");
        rd_exp(0, 5'h0C, 32'd4, 1'b0, "t6_id4");
        rd_exp(0, 5'h0C, 32'd5, 1'b0, "t6_id5");
        rd_exp(0, 5'h14, 32'h0006_0300, 1'b0, "t6_status_busy");
        @(posedge clk); #1; rst = 1'b1; if1.trans_complete_i = 4'b1111;
        @(posedge clk); #1; rst = 1'b0; if1.trans_complete_i = 4'b0000;
        @(negedge clk);
        chk("t6_valid", if1.valid_o, 4'b0000);
        rd_exp(0, 5'h14, 32'h0000_0001, 1'b0, "t6_status_after");
        rd_exp(0, 5'h10, 32'd0, 1'b0, "t6_completed");

        // T5: 2-bit IDs wrap, simultaneous completions all counted
        wr(1, 5'h08, 32'd4);
        for (int i = 0; i < 5; i++) rd_exp(1, 5'h0C, 32'(i % 4), 1'b0, "t5_id");
        @(posedge clk); #1; if2.trans_complete_i = 4'b0111;
        @(posedge clk); #1; if2.trans_complete_i = 4'b0000;
        rd_exp(1, 5'h10, 32'd3, 1'b0, "t5_completed3");
        @(posedge clk); #1; if2.trans_complete_i = 4'b1111;
        @(posedge clk); #1; if2.trans_complete_i = 4'b0000;
        rd_exp(1, 5'h10, 32'd3, 1'b0, "t5_completed_wrap");
        rd_exp(1, 5'h14, 32'h0001_0001, 1'b0, "t5_status");

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
